md_engine: RTL and testbench

MD_ENGINE -- requirements
Module: md_engine

---
 rtl/md_pkg.sv | 26 ++
 rtl/md_engine_if.sv | 30 +++
 rtl/md_divider.sv | 43 ++++
 rtl/md_engine.sv | 119 +++++++++++
 tb/tb_md_engine.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide engine: op encodings,
// FSM state encoding and default cycle counts.
package md_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  function automatic int max_cycles(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/md_engine_if.sv
// Command/result bundle of md_engine; master drives commands, slave is the engine.
interface md_engine_if import md_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
);
  // Handshake: start is a one-cycle request, taken only while busy is low
  // (and flush is low); while busy is high, start and wr_hi/wr_lo are ignored.
  logic             start;
  md_op_e           op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             wr_hi;
  logic             wr_lo;
  logic             flush;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div0;
  md_state_e        state;

  modport master (
    output start, op, src_a, src_b, wr_hi, wr_lo, flush,
    input  busy, hi, lo, div0, state
  );

  modport slave (
    input  start, op, src_a, src_b, wr_hi, wr_lo, flush,
    output busy, hi, lo, div0, state
  );

endinterface

// File: rtl/md_divider.sv
// Combinational signed/unsigned divider on latched operands, including the
// divide-by-zero and most-negative / -1 results.
module md_divider import md_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_zero
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, q_mag, r_mag;

  always_comb begin
    a_neg    = is_signed & dividend[WIDTH-1];
    b_neg    = is_signed & divisor[WIDTH-1];
    a_mag    = a_neg ? -dividend : dividend;
    b_mag    = b_neg ? -divisor : divisor;
    div_zero = (divisor == '0);
    q_mag    = '0;
    r_mag    = '0;
    if (!div_zero) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    // Truncation toward zero: quotient sign from both operands, remainder from dividend.
    quot = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem  = a_neg ? -r_mag : r_mag;
    if (div_zero) begin
      quot = '1;
      rem  = dividend;
    end else if (is_signed && dividend == MOST_NEG && divisor == '1) begin
      quot = MOST_NEG;
      rem  = '0;
    end
  end

endmodule

// File: rtl/md_engine.sv
// Multi-cycle HI/LO multiply/divide engine. Optional MD_FLUSH_EN makes the
// flush input abort operations and suppress HI/LO writes.
module md_engine import md_pkg::*; #(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  md_engine_if.slave  bus
);

  localparam int CNT_W = $clog2(max_cycles(MULT_CYCLES, DIV_CYCLES) + 1);

  md_state_e              state, state_n;
  logic [CNT_W-1:0]       cnt;
  md_op_e                 op_r;
  logic [WIDTH-1:0]       a_r, b_r;
  logic [WIDTH-1:0]       hi_r, lo_r;
  logic                   div0_r;
  logic                   flush_eff;
  logic                   accept, complete, idle_write;
  logic                   mul_signed;
  logic [2*WIDTH-1:0]     product;
  logic [WIDTH-1:0]       quot, rem;
  logic                   div_zero;

`ifdef MD_FLUSH_EN
  assign flush_eff = bus.flush;
`else
  logic unused_flush;
  assign unused_flush = bus.flush;
  assign flush_eff    = 1'b0;
`endif

  // One 2W-bit multiplier serves both flavours; signedness only changes the extension.
  assign mul_signed = (op_r == OP_MULT);
  assign product    = {{WIDTH{mul_signed & a_r[WIDTH-1]}}, a_r} *
                      {{WIDTH{mul_signed & b_r[WIDTH-1]}}, b_r};

  md_divider #(.WIDTH(WIDTH)) u_divider (
    .dividend  (a_r),
    .divisor   (b_r),
    .is_signed (op_r == OP_DIV),
    .quot      (quot),
    .rem       (rem),
    .div_zero  (div_zero)
  );

  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    complete = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start && !flush_eff) begin
          accept  = 1'b1;
          state_n = bus.op[1] ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL, ST_DIV: begin
        if (flush_eff) begin
          state_n = ST_IDLE;
        end else if (cnt == CNT_W'(1)) begin
          complete = 1'b1;
          state_n  = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Register writes are taken only in IDLE when no start or flush competes.
  assign idle_write = (state == ST_IDLE) && !bus.start && !flush_eff;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      op_r   <= OP_MULT;
      a_r    <= '0;
      b_r    <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      div0_r <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_r <= bus.op;
        a_r  <= bus.src_a;
        b_r  <= bus.src_b;
        cnt  <= bus.op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (state_n == ST_IDLE) begin
        cnt <= '0;
      end else begin
        cnt <= cnt - 1'b1;
      end
      if (complete) begin
        if (op_r[1]) begin
          hi_r   <= rem;
          lo_r   <= quot;
          div0_r <= div_zero;
        end else begin
          {hi_r, lo_r} <= product;
        end
      end else if (idle_write) begin
        if (bus.wr_hi) hi_r <= bus.src_a;
        if (bus.wr_lo) lo_r <= bus.src_a;
      end
    end
  end

  assign bus.busy  = (state != ST_IDLE);
  assign bus.hi    = hi_r;
  assign bus.lo    = lo_r;
  assign bus.div0  = div0_r;
  assign bus.state = state;

endmodule

// File: tb/tb_md_engine.sv
// Self-checking bench for md_engine: scoreboard of {div0, hi, lo} results,
// directed corner cases plus random operations.
module tb_md_engine;
  import md_pkg::*;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;

  md_engine_if #(.WIDTH(W)) bus();

  md_engine #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [2*W:0]   exp_q[$];
  logic [W-1:0]   exp_hi, exp_lo;
  logic           exp_div0;

  task automatic check(input string tag, input logic [2*W:0] got, input logic [2*W:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: {div0, hi, lo} after the op, given the current div0.
  function automatic logic [2*W:0] model(input md_op_e op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic d0);
    longint        sa, sb, q, r;
    logic [2*W-1:0] p;
    logic [2*W:0]  res;
    if (op == OP_MULT) begin
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      p   = sa * sb;
      res = {d0, p};
    end else if (op == OP_MULTU) begin
      p   = {32'b0, a} * {32'b0, b};
      res = {d0, p};
    end else if (b == '0) begin
      res = {1'b1, a, {W{1'b1}}};
    end else begin
      if (op == OP_DIV) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'b0, a});
        sb = longint'({32'b0, b});
      end
      q   = sa / sb;
      r   = sa % sb;
      res = {1'b0, r[W-1:0], q[W-1:0]};
    end
    return res;
  endfunction

  // Driver: called at a negedge, drives start for one cycle; returns at cycle T+1.
  task automatic issue(input md_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic with_wr_lo = 1'b0);
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    bus.start = 1'b1;
    bus.wr_lo = with_wr_lo;
    exp_q.push_back(model(op, a, b, exp_div0));
    @(negedge clk);
    bus.start = 1'b0;
    bus.wr_lo = 1'b0;
  endtask

  // Counts busy cycles (pre already elapsed) and compares the popped result.
  task automatic wait_done(input int n, input int pre, input string tag);
    int           cnt;
    logic [2*W:0] e;
    cnt = pre;
    while (bus.busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, (2*W+1)'(cnt), (2*W+1)'(n));
    e = exp_q.pop_front();
    {exp_div0, exp_hi, exp_lo} = e;
    check(tag, {bus.div0, bus.hi, bus.lo}, e);
  endtask

  task automatic run(input md_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input string tag);
    issue(op, a, b);
    wait_done(op[1] ? DC : MC, 0, tag);
  endtask

  task automatic check_regs(input string tag);
    check(tag, {bus.div0, bus.hi, bus.lo}, {exp_div0, exp_hi, exp_lo});
  endtask

  initial begin
    md_op_e       rop;
    logic [W-1:0] ra, rb;

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = OP_MULT;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
    bus.flush = 1'b0;
    exp_hi    = '0;
    exp_lo    = '0;
    exp_div0  = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", (2*W+1)'(bus.busy), '0);
    check("reset_state", (2*W+1)'(bus.state), (2*W+1)'(ST_IDLE));
    check_regs("reset_regs");
    reset = 1'b0;
    @(negedge clk);

    // Directed arithmetic cases
    run(OP_MULT,  32'hFFFF_FFFE, 32'd3, "mult_neg");
    run(OP_DIVU,  32'd7, 32'd2, "divu_7_2");
    run(OP_DIV,   32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run(OP_DIV,   32'h0000_1234, 32'd0, "div_zero");
    run(OP_DIVU,  32'd4, 32'd2, "divu_clears_div0");
    run(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    run(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run(OP_MULT,  32'h8000_0000, 32'h8000_0000, "mult_most_neg");
    run(OP_DIVU,  32'h8000_0000, 32'hFFFF_FFFF, "divu_big");

    // Start and write while busy are ignored; operands were latched
    issue(OP_MULTU, 32'd6, 32'd7);
    bus.wr_hi = 1'b1;
    bus.start = 1'b1;
    bus.op    = OP_DIV;
    bus.src_a = 32'h0000_00AA;
    @(negedge clk);
    bus.wr_hi = 1'b0;
    bus.start = 1'b0;
    wait_done(MC, 1, "busy_ignores_start_wr");

    // Writes in IDLE
    bus.wr_hi = 1'b1;
    bus.src_a = 32'h0000_00AA;
    @(negedge clk);
    bus.wr_hi = 1'b0;
    exp_hi    = 32'h0000_00AA;
    check_regs("wr_hi_idle");
    bus.wr_lo = 1'b1;
    bus.src_a = 32'h0000_0055;
    @(negedge clk);
    bus.wr_lo = 1'b0;
    exp_lo    = 32'h0000_0055;
    check_regs("wr_lo_idle");

    // Start wins over a simultaneous write
    issue(OP_MULTU, 32'd3, 32'd4, 1'b1);
    wait_done(MC, 0, "start_beats_wr_lo");

    // Flush at busy cycle 3
    issue(OP_MULT, 32'd5, 32'd6);
    repeat (2) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
`ifdef MD_FLUSH_EN
    void'(exp_q.pop_back());
    check("flush_busy", (2*W+1)'(bus.busy), '0);
    check_regs("flush_keeps_regs");
    // Flush at the completion cycle wins over the result
    issue(OP_DIVU, 32'd50, 32'd5);
    repeat (DC - 1) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    void'(exp_q.pop_back());
    check("flush_last_busy", (2*W+1)'(bus.busy), '0);
    check_regs("flush_last_regs");
    // Flush in IDLE suppresses writes and blocks start
    bus.flush = 1'b1;
    bus.wr_hi = 1'b1;
    bus.start = 1'b1;
    bus.src_a = 32'h1357_9BDF;
    @(negedge clk);
    bus.flush = 1'b0;
    bus.wr_hi = 1'b0;
    bus.start = 1'b0;
    check("flush_idle_busy", (2*W+1)'(bus.busy), '0);
    check_regs("flush_idle_regs");
`else
    wait_done(MC, 3, "flush_ignored");
`endif

    // Reset during divide busy cycle 4
    run(OP_DIV, 32'd9, 32'd0, "div0_before_reset");
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    void'(exp_q.pop_back());
    exp_hi   = '0;
    exp_lo   = '0;
    exp_div0 = 1'b0;
    check("reset_mid_busy", (2*W+1)'(bus.busy), '0);
    check_regs("reset_mid_regs");
    run(OP_DIVU, 32'd9, 32'd4, "start_after_reset");

    // Random back-to-back operations
    for (int i = 0; i < 24; i++) begin
      rop = md_op_e'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? '0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
      run(rop, ra, rb, "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
